// File: rtl/vgapat_pkg.sv
// Shared mode codes and colour-bar helpers for the video test-pattern source.
`timescale 1ns/1ps
package vgapat_pkg;

  // Pattern selector values carried on i_mode / o_mode; 6 and 7 render black.
  typedef enum logic [2:0] {
    MODE_BARS     = 3'd0,
    MODE_CHECKER  = 3'd1,
    MODE_GRADIENT = 3'd2,
    MODE_SCROLL   = 3'd3,
    MODE_SOLID    = 3'd4,
    MODE_BORDER   = 3'd5
  } mode_e;

  // Widest colour channel the expansion helper can produce.
  localparam int MAX_BPC = 16;

  // Bar colours as {R,G,B} on/off flags, bars ordered left to right.
  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    logic [2:0] flags;
    case (idx)
      3'd0:    flags = 3'b111;
      3'd1:    flags = 3'b110;
      3'd2:    flags = 3'b011;
      3'd3:    flags = 3'b010;
      3'd4:    flags = 3'b101;
      3'd5:    flags = 3'b100;
      3'd6:    flags = 3'b001;
      default: flags = 3'b000;
    endcase
    return flags;
  endfunction

  // Turns each flag into a full-scale or zero channel of bpc bits, packed {R,G,B}.
  function automatic logic [3*MAX_BPC-1:0] expand_flags(input logic [2:0] flags,
                                                        input int unsigned bpc);
    logic [3*MAX_BPC-1:0] mask;
    logic [3*MAX_BPC-1:0] res;
    mask = ~({(3*MAX_BPC){1'b1}} << bpc);
    res  = (({(3*MAX_BPC){flags[2]}} & mask) << (2*bpc))
         | (({(3*MAX_BPC){flags[1]}} & mask) << bpc)
         |  ({(3*MAX_BPC){flags[0]}} & mask);
    return res;
  endfunction

endpackage

// File: rtl/vgapat_barcnt.sv
// Bar position counter: pixels within the current bar and which bar we are in.
// Shared by the static and the scrolling colour-bar modes.
`timescale 1ns/1ps
module vgapat_barcnt
  import vgapat_pkg::*;
#(
  parameter int LGW = 12
) (
  input  logic           i_pixclk,
  input  logic           i_reset,
  input  logic           load,
  input  logic [2:0]     start_bar,
  input  logic [LGW-1:0] start_sub,
  input  logic           advance,
  input  logic [LGW-1:0] bw,
  input  logic           wrap,
  output logic [2:0]     bar,
  output logic [LGW-1:0] sub
);

  // Load a line-start position, or step one pixel; the last bar either holds or wraps to the first.
  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      bar <= '0;
      sub <= '0;
    end else if (load) begin
      bar <= start_bar;
      sub <= start_sub;
    end else if (advance) begin
      if (sub >= bw - LGW'(1)) begin
        sub <= '0;
        if (wrap || (bar != 3'd7))
          bar <= bar + 3'd1;
      end else begin
        sub <= sub + LGW'(1);
      end
    end
  end

endmodule

// File: rtl/vgapatgen.sv
// Multi-mode video test-pattern source driven by the sink's pull handshake.
// o_pixel is combinational from the current (x,y) position and frame state.
`timescale 1ns/1ps
module vgapatgen
  import vgapat_pkg::*;
#(
  parameter int BITS_PER_COLOR = 8,
  parameter int LGW            = 12,
  parameter int LGH            = 11,
  parameter int CHECK_LOG2     = 5
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset,
  input  logic [LGW-1:0]              i_width,
  input  logic [LGH-1:0]              i_height,
  input  logic [2:0]                  i_mode,
  input  logic [3*BITS_PER_COLOR-1:0] i_solid,
  input  logic                        i_rd,
  input  logic                        i_newline,
  input  logic                        i_newframe,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel,
  output logic [2:0]                  o_mode,
  output logic [15:0]                 o_frame
);

  localparam int PIX_W = 3*BITS_PER_COLOR;
  localparam int BPC   = BITS_PER_COLOR;

  logic [LGW-1:0] x;
  logic [LGH-1:0] y;
  logic [2:0]     mode;
  logic [15:0]    frame;
  logic [LGW-1:0] bw;
  logic [2:0]     scroll_bar;
  logic [LGW-1:0] scroll_sub;

  logic [LGW-1:0] width_div;
  logic [LGW-1:0] bw_next;
  logic [2:0]     scroll_bar_next;
  logic [LGW-1:0] scroll_sub_next;

  logic           bc_load;
  logic           bc_advance;
  logic           bc_wrap;
  logic [2:0]     bc_start_bar;
  logic [LGW-1:0] bc_start_sub;
  logic [2:0]     bar;
  logic [LGW-1:0] bar_sub;

  logic             active;
  logic             on_border;
  logic [PIX_W-1:0] bar_rgb;

  // Bar width for the coming frame and the scroll offset one pixel further on, measured in that width.
  always_comb begin
    width_div = i_width >> 3;
    bw_next   = (width_div == '0) ? LGW'(1) : width_div;
    if (scroll_sub >= bw_next - LGW'(1)) begin
      scroll_sub_next = '0;
      scroll_bar_next = scroll_bar + 3'd1;
    end else begin
      scroll_sub_next = scroll_sub + LGW'(1);
      scroll_bar_next = scroll_bar;
    end
  end

  // Raster position, frame-level state and scroll offset; newframe beats newline beats read.
  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      x          <= '0;
      y          <= '0;
      mode       <= '0;
      frame      <= '0;
      bw         <= LGW'(1);
      scroll_bar <= '0;
      scroll_sub <= '0;
    end else if (i_newframe) begin
      x          <= '0;
      y          <= '0;
      mode       <= i_mode;
      frame      <= frame + 16'd1;
      bw         <= bw_next;
      scroll_bar <= scroll_bar_next;
      scroll_sub <= scroll_sub_next;
    end else if (i_newline) begin
      x <= '0;
      if (y != '1)
        y <= y + LGH'(1);
    end else if (i_rd) begin
      if (x != '1)
        x <= x + LGW'(1);
    end
  end

  // Bar counter restarts each line at bar 0, or at the scroll offset when scrolling.
  always_comb begin
    bc_load      = i_newframe | i_newline;
    bc_advance   = i_rd & ~bc_load;
    bc_wrap      = (mode == MODE_SCROLL);
    bc_start_bar = '0;
    bc_start_sub = '0;
    if (i_newframe) begin
      if (i_mode == MODE_SCROLL) begin
        bc_start_bar = scroll_bar_next;
        bc_start_sub = scroll_sub_next;
      end
    end else if (mode == MODE_SCROLL) begin
      bc_start_bar = scroll_bar;
      bc_start_sub = scroll_sub;
    end
  end

  vgapat_barcnt #(
    .LGW(LGW)
  ) u_barcnt (
    .i_pixclk  (i_pixclk),
    .i_reset   (i_reset),
    .load      (bc_load),
    .start_bar (bc_start_bar),
    .start_sub (bc_start_sub),
    .advance   (bc_advance),
    .bw        (bw),
    .wrap      (bc_wrap),
    .bar       (bar),
    .sub       (bar_sub)
  );

  // Pixel colour for the current position; anything outside the active area is black.
  always_comb begin
    active    = (x < i_width) && (y < i_height);
    on_border = (x == '0) || (y == '0) ||
                (x == i_width - LGW'(1)) || (y == i_height - LGH'(1));
    bar_rgb   = PIX_W'(expand_flags(bar_flags(bar), BITS_PER_COLOR));
    o_pixel   = '0;
    if (active) begin
      case (mode)
        MODE_BARS, MODE_SCROLL: o_pixel = bar_rgb;
        MODE_CHECKER:           o_pixel = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? '1 : '0;
        MODE_GRADIENT:          o_pixel = {x[BPC-1:0], y[BPC-1:0], frame[BPC-1:0]};
        MODE_SOLID:             o_pixel = i_solid;
        MODE_BORDER:            o_pixel = on_border ? '1 : '0;
        default:                o_pixel = '0;
      endcase
    end
  end

  assign o_mode  = mode;
  assign o_frame = frame;

endmodule

// File: tb/tb_vgapatgen.sv
// Self-checking bench for vgapatgen: directed scenarios with literal expectations
// plus randomized frames checked every cycle against a behavioural raster model.
`timescale 1ns/1ps
module tb_vgapatgen;

  logic        i_pixclk = 1'b0;
  logic        i_reset = 1'b0;
  logic [11:0] i_width = 12'd640;
  logic [10:0] i_height = 11'd480;
  logic [2:0]  i_mode = 3'd0;
  logic [23:0] i_solid = 24'h0;
  logic        i_rd = 1'b0;
  logic        i_newline = 1'b0;
  logic        i_newframe = 1'b0;
  logic [23:0] o_pixel;
  logic [2:0]  o_mode;
  logic [15:0] o_frame;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  localparam logic [23:0] BAR_LIT [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Model state: position, frame info, scroll offset, line start bar/sub and reads since line start.
  int mx, my, mmode, mframe, mbw, ssub, sbar, lbar, lsub, cnt;

  always #5 i_pixclk = ~i_pixclk;

  vgapatgen dut (
    .i_pixclk   (i_pixclk),
    .i_reset    (i_reset),
    .i_width    (i_width),
    .i_height   (i_height),
    .i_mode     (i_mode),
    .i_solid    (i_solid),
    .i_rd       (i_rd),
    .i_newline  (i_newline),
    .i_newframe (i_newframe),
    .o_pixel    (o_pixel),
    .o_mode     (o_mode),
    .o_frame    (o_frame)
  );

  function automatic int calc_bw(input int w);
    int b;
    b = w / 8;
    return (b == 0) ? 1 : b;
  endfunction

  function automatic int sub_after(input int s, input int b);
    return (s >= b - 1) ? 0 : s + 1;
  endfunction

  function automatic int bar_after(input int s, input int br, input int b);
    return (s >= b - 1) ? (br + 1) % 8 : br;
  endfunction

  // Behavioural raster model updated on the same events as the design.
  always @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      mx <= 0; my <= 0; mmode <= 0; mframe <= 0; mbw <= 1;
      ssub <= 0; sbar <= 0; lbar <= 0; lsub <= 0; cnt <= 0;
    end else if (i_newframe) begin
      mx     <= 0;
      my     <= 0;
      mmode  <= int'(i_mode);
      mframe <= (mframe + 1) % 65536;
      mbw    <= calc_bw(int'(i_width));
      ssub   <= sub_after(ssub, calc_bw(int'(i_width)));
      sbar   <= bar_after(ssub, sbar, calc_bw(int'(i_width)));
      if (i_mode == 3'd3) begin
        lsub <= sub_after(ssub, calc_bw(int'(i_width)));
        lbar <= bar_after(ssub, sbar, calc_bw(int'(i_width)));
      end else begin
        lsub <= 0;
        lbar <= 0;
      end
      cnt <= 0;
    end else if (i_newline) begin
      mx <= 0;
      my <= (my < 2047) ? my + 1 : my;
      if (mmode == 3) begin
        lbar <= sbar;
        lsub <= ssub;
      end else begin
        lbar <= 0;
        lsub <= 0;
      end
      cnt <= 0;
    end else if (i_rd) begin
      mx  <= (mx < 4095) ? mx + 1 : mx;
      cnt <= cnt + 1;
    end
  end

  function automatic logic [23:0] model_pixel();
    int bar;
    if (mx >= int'(i_width) || my >= int'(i_height)) return 24'h0;
    case (mmode)
      0: begin
        bar = cnt / mbw;
        if (bar > 7) bar = 7;
        return BAR_LIT[bar];
      end
      3: begin
        bar = ((lbar * mbw + lsub + cnt) / mbw) % 8;
        return BAR_LIT[bar];
      end
      1: return ((((mx / 32) ^ (my / 32)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      2: return {8'(mx % 256), 8'(my % 256), 8'(mframe % 256)};
      4: return i_solid;
      5: return (mx == 0 || my == 0 || mx == int'(i_width) - 1 || my == int'(i_height) - 1)
                ? 24'hFFFFFF : 24'h000000;
      default: return 24'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [23:0] got, input logic [23:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Every-cycle comparison of the design against the model, sampled on the falling edge.
  always @(negedge i_pixclk) begin
    if (chk_en) begin
      checkOutput($sformatf("pixel x=%0d y=%0d mode=%0d", mx, my, mmode), o_pixel, model_pixel());
      checkOutput("mode", {21'b0, o_mode}, 24'(mmode));
      checkOutput("frame", {8'b0, o_frame}, 24'(mframe));
    end
  end

  // One cycle of handshake inputs, changed away from both clock edges.
  task automatic applyStimulus(input bit rd, input bit nl, input bit nf);
    @(negedge i_pixclk);
    #2;
    i_rd = rd;
    i_newline = nl;
    i_newframe = nf;
    #1;
  endtask

  task automatic pulseReset();
    @(negedge i_pixclk);
    #2;
    i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0;
    i_reset = 1'b1;
    @(negedge i_pixclk);
    #2;
    i_reset = 1'b0;
    #1;
  endtask

  initial begin
    #1 i_reset = 1'b1;
    repeat (3) @(negedge i_pixclk);
    #2 i_reset = 1'b0;
    #1;
    chk_en = 1'b1;
    checkOutput("reset pixel", o_pixel, 24'hFFFFFF);
    checkOutput("reset frame", {8'b0, o_frame}, 24'd0);
    checkOutput("reset mode", {21'b0, o_mode}, 24'd0);

    // Colour bars across a 640-pixel line, then one blanked read.
    i_mode = 3'd0;
    applyStimulus(0, 0, 1);
    for (int px = 0; px < 640; px++) begin
      applyStimulus(1, 0, 0);
      if ((px % 80 == 0) || (px % 80 == 79))
        checkOutput($sformatf("bars x=%0d", px), o_pixel, BAR_LIT[px / 80]);
    end
    applyStimulus(0, 0, 0);
    checkOutput("bars x=640 blank", o_pixel, 24'h000000);

    // Reset in the middle of a line.
    applyStimulus(0, 1, 0);
    repeat (100) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("bars x=100", o_pixel, 24'hFFFF00);
    i_reset = 1'b1;
    #1;
    checkOutput("midline reset pixel", o_pixel, 24'hFFFFFF);
    checkOutput("midline reset frame", {8'b0, o_frame}, 24'd0);
    checkOutput("midline reset mode", {21'b0, o_mode}, 24'd0);
    @(negedge i_pixclk);
    #2 i_reset = 1'b0;
    #1;
    applyStimulus(1, 0, 0);
    checkOutput("post reset x=0", o_pixel, 24'hFFFFFF);
    applyStimulus(0, 0, 0);
    checkOutput("post reset x=1 bw=1", o_pixel, 24'hFFFF00);

    // Checkerboard square edges.
    i_mode = 3'd1;
    applyStimulus(0, 0, 1);
    repeat (31) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("checker x=31 y=0", o_pixel, 24'h000000);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("checker x=32 y=0", o_pixel, 24'hFFFFFF);
    repeat (32) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("checker x=0 y=32", o_pixel, 24'hFFFFFF);

    // Mode request mid-frame waits for the next frame.
    i_mode = 3'd4;
    i_solid = 24'h123456;
    applyStimulus(0, 0, 0);
    checkOutput("solid pending pixel", o_pixel, 24'hFFFFFF);
    checkOutput("solid pending mode", {21'b0, o_mode}, 24'd1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("solid mode", {21'b0, o_mode}, 24'd4);
    checkOutput("solid x=0", o_pixel, 24'h123456);
    repeat (5) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("solid x=5", o_pixel, 24'h123456);

    // Scrolling bars: three frames in, bar 1 begins at x=77.
    pulseReset();
    i_mode = 3'd3;
    repeat (3) applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("scroll f3 x=0", o_pixel, 24'hFFFFFF);
    repeat (76) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("scroll f3 x=76", o_pixel, 24'hFFFFFF);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("scroll f3 x=77", o_pixel, 24'hFFFF00);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("scroll f3 y=1 x=0", o_pixel, 24'hFFFFFF);
    repeat (637) applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("scroll f640 frame", {8'b0, o_frame}, 24'd640);
    repeat (79) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("scroll f640 x=79", o_pixel, 24'hFFFFFF);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("scroll f640 x=80", o_pixel, 24'hFFFF00);

    // All three controls together: only the frame restart takes effect.
    i_mode = 3'd2;
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 0);
    checkOutput("collide frame", {8'b0, o_frame}, 24'd641);
    checkOutput("collide gradient x=0 y=0", o_pixel, 24'h000081);

    // Narrow line: bar width forced to one pixel.
    i_width = 12'd5;
    i_mode = 3'd0;
    applyStimulus(0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0);
      checkOutput($sformatf("width5 x=%0d", k), o_pixel, BAR_LIT[k]);
    end
    applyStimulus(0, 0, 0);
    checkOutput("width5 x=5 blank", o_pixel, 24'h000000);

    // Randomized frames checked cycle by cycle against the model.
    for (int f = 0; f < 25; f++) begin
      int nrd;
      i_width  = 12'($urandom_range(8, 80));
      i_height = 11'($urandom_range(2, 12));
      i_mode   = 3'($urandom_range(0, 7));
      i_solid  = 24'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      for (int l = 0; l < int'(i_height) + 2; l++) begin
        nrd = $urandom_range(0, int'(i_width) + 3);
        for (int r = 0; r < nrd; r++) begin
          if ($urandom_range(0, 99) == 0) i_mode = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 299) == 0) i_width = 12'($urandom_range(8, 80));
          applyStimulus($urandom_range(0, 3) != 0, 1'b0, 1'b0);
        end
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        if (f == 12 && l == 3) pulseReset();
      end
    end

    applyStimulus(0, 0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
